sig_change_logger: RTL
======================

# sig_change_logger

Event-capture stage that sits directly downstream of a combinational unit under test, such as the half adder (x, y, s, c). Each enabled clock it samples a bus of monitored signals and detects which bits changed since the previous sample. It serializes the changes, lowest index first, into timestamped (time, id, value) events and buffers them in a FIFO. A valid/ready port drains the FIFO to the .sim file writer or trace sink.

## Interface
- NSIG, 4: number of monitored signals (1..16)
- TS_W, 16: timestamp width
- DEPTH, 8: event FIFO depth (power of two, ≥2)
- ID_W, max(1, clog2(NSIG)): event id width (derived, localparam)
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sampling enable; timestamp counts only while high
- sig_in  in  NSIG  monitored signals (e.g. {c, s, y, x} = bits 3..0)
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_time  out  TS_W  timestamp of head event
- ev_id  out  ID_W  signal index of head event
- ev_value  out  1  new value of that signal
- count  out  clog2(DEPTH)+1  events currently in FIFO
- overflow  out  1  sticky: at least one change was dropped

## Operation
- Reset (async assert, sync-safe deassert) clears the timestamp counter ts, the prev register, pending mask P, pending time/values, the FIFO pointers and overflow, and sets armed=0. Outputs: ev_valid=0, count=0, overflow=0, ev_time/ev_id/ev_value=0.
- Enabled edge (en=1):
  - The change mask is M = armed ? (sig_in ^ prev) : all-ones. The first enabled edge after reset logs a full initial snapshot.
  - prev <= sig_in; armed <= 1; ts <= ts+1, wrapping modulo 2^TS_W.
  - If M≠0 and P will be empty this edge, load P<=M, PT<=ts (pre-increment), PV<=sig_in.
  - If M≠0 and P will still be non-empty after this edge's push, the changes are dropped and overflow<=1. prev still updates, so the dropped changes are lost.
- With en=0: ts, prev and armed hold, and no detection occurs. The serializer and FIFO keep operating.
- Serializer: when P≠0 and a FIFO push is permitted, it pushes {PT, i, PV[i]} for the lowest set i and clears bit i. A push is permitted when FIFO is not full, or when it is full and a pop occurs the same cycle. While blocked, P holds; this is a stall, not a drop.
- FIFO: show-ahead, with head fields driven from storage. Pop on ev_valid & ev_ready. Simultaneous push/pop leaves count unchanged. Pointers wrap modulo DEPTH.
- ev_ready while ev_valid=0 has no effect.
- overflow clears only on reset.

## Timing
- Change sampled at edge E0 → P loaded at E0 → event pushed at E1 → ev_valid visible after E1. Latency is one cycle for the first event.
- k simultaneous changes enter the FIFO on k consecutive cycles (E1..Ek), absent backpressure. All k carry the same ev_time.
- P counts as empty at E0 if it is empty before E0, or if it holds one bit and that bit pushes at E0. Back-to-back single-bit changes on consecutive cycles therefore never drop.
- Full FIFO with ev_ready=0: the serializer stalls. Any change detected at an edge where P stays non-empty sets overflow at that edge.
- Reset asserted mid-operation: all state clears immediately; pending and buffered events are discarded.

## Test plan
- Reset, then en=1 with sig_in=4'b0000 → 4 events at ev_time=0, ids 0,1,2,3, value 0, with ev_valid rising one cycle after the first enabled edge.
- Drive half-adder vectors (x,y)=00,01,10,11 every 10 cycles on {c,s,y,x} with ev_ready=1 → events (10,y,1), (10,s,1), (20,x,1), (20,y,0), (30,y,1), (30,s,0), (30,c,1) in that order.
- Hold ev_ready=0 and toggle bit0 every cycle → count saturates at DEPTH=8, overflow=1 on the first stalled-and-busy change, and the 8 buffered events retain correct timestamps.
- en low for 5 cycles while sig_in toggles, then high → ts unchanged across the gap, and one event per bit differing from the last enabled sample.
- TS_W=4, run 20 enabled cycles with a change at cycle 17 → ev_time=1 (wrap).
- Assert rst_n mid-burst with count=3 → ev_valid=0, count=0, and overflow=0 immediately (asynchronous). The next enabled edge emits a new snapshot.

Source files
------------

// File: rtl/sig_change_logger.sv
// sig_change_logger: samples a bus of monitored signals on enabled clocks,
// turns every changed bit into a timestamped (time, id, value) event
// (lowest index first) and buffers the events in a show-ahead FIFO that
// is drained through a valid/ready port.
module sig_change_logger #(
  parameter  int NSIG  = 4,
  parameter  int TS_W  = 16,
  parameter  int DEPTH = 8,
  localparam int ID_W  = (NSIG > 1) ? $clog2(NSIG) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NSIG-1:0]  sig_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_time,
  output logic [ID_W-1:0]  ev_id,
  output logic             ev_value,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Sampler state
  logic [TS_W-1:0] ts;
  logic [NSIG-1:0] prev;
  logic            armed;

  // Pending change set waiting to be serialized
  logic [NSIG-1:0] pend;
  logic [TS_W-1:0] pend_time;
  logic [NSIG-1:0] pend_val;

  // Event storage
  logic [TS_W-1:0]  mem_time [DEPTH];
  logic [ID_W-1:0]  mem_id   [DEPTH];
  logic [DEPTH-1:0] mem_val;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Combinational control
  logic            pop;
  logic            full;
  logic            push;
  logic [ID_W-1:0] sel_id;
  logic [NSIG-1:0] sel_onehot;
  logic            sel_found;
  logic [NSIG-1:0] pend_after;
  logic [NSIG-1:0] change;
  logic            detect;
  logic            load;
  logic            drop;

  assign ev_valid = (cnt != '0);
  assign count    = cnt;
  assign ev_time  = mem_time[rd_ptr];
  assign ev_id    = mem_id[rd_ptr];
  assign ev_value = mem_val[rd_ptr];

  assign pop  = ev_valid & ev_ready;
  assign full = (cnt == CNT_W'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = (pend != '0) && (!full || pop);

  // Lowest set bit of the pending mask selects the next event to emit
  always_comb begin
    sel_id     = '0;
    sel_onehot = '0;
    sel_found  = 1'b0;
    for (int unsigned i = 0; i < NSIG; i++) begin
      if (pend[i] && !sel_found) begin
        sel_id        = ID_W'(i);
        sel_onehot[i] = 1'b1;
        sel_found     = 1'b1;
      end
    end
  end

  // Pending mask as it stands after this cycle's push; a new change set may
  // only be accepted when this is empty, so a single-bit set leaving this
  // cycle makes room for back-to-back changes.
  assign pend_after = push ? (pend & ~sel_onehot) : pend;
  assign change     = armed ? (sig_in ^ prev) : '1;
  assign detect     = en && (change != '0);
  assign load       = detect && (pend_after == '0);
  assign drop       = detect && (pend_after != '0);

  // Timestamp counter and previous-sample register advance on enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts    <= '0;
      prev  <= '0;
      armed <= 1'b0;
    end else if (en) begin
      ts    <= ts + 1'b1;
      prev  <= sig_in;
      armed <= 1'b1;
    end
  end

  // Pending change set: drained bit by bit, reloaded when empty, sticky overflow on drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_time <= '0;
      pend_val  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        pend      <= change;
        pend_time <= ts;
        pend_val  <= sig_in;
      end else begin
        pend      <= pend_after;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Event FIFO: write at wr_ptr, show-ahead read at rd_ptr, occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_time[i] <= '0;
        mem_id[i]   <= '0;
      end
      mem_val <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (push) begin
        mem_time[wr_ptr] <= pend_time;
        mem_id[wr_ptr]   <= sel_id;
        mem_val[wr_ptr]  <= |(pend_val & sel_onehot);
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
